// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an iterative shift-add / restoring-divide
// unit that owns the architectural HI/LO registers and stalls upstream while busy.
module ex_stage #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [2:0]    ex_alusel,
    input  logic [4:0]    ex_aluop,
    input  logic [DW-1:0] ex_srcl,
    input  logic [DW-1:0] ex_srcr,
    input  logic [15:0]   ex_offset,
    input  logic [2:0]    ex_memop,
    input  logic [4:0]    ex_dest,
    input  logic          ex_writeEnable,
    output logic [DW-1:0] mem_result,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_storedata,
    output logic [2:0]    mem_memop,
    output logic [4:0]    mem_dest,
    output logic          mem_writeEnable,
    output logic          ovf_exc,
    output logic          stall_req
);
    localparam int SW = $clog2(DW);
    localparam int CW = $clog2(DW);

    localparam logic [2:0] SEL_LOGIC  = 3'd1;
    localparam logic [2:0] SEL_SHIFT  = 3'd2;
    localparam logic [2:0] SEL_ARITH  = 3'd3;
    localparam logic [2:0] SEL_MULDIV = 3'd4;
    localparam logic [2:0] SEL_MOVE   = 3'd5;

    localparam logic [4:0] MD_MTHI = 5'd4;
    localparam logic [4:0] MD_MTLO = 5'd5;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   hi, lo;
    logic [2*DW-1:0] acc;
    logic [DW-1:0]   mcand;
    logic            op_div, neg_q, neg_r;

    // ---------------- mul/div issue decode ----------------
    logic          md_start, md_is_div, md_signed, div_zero, issue;
    logic          a_neg, b_neg;
    logic [DW-1:0] a_abs, b_abs;

    always_comb begin
        md_start  = (ex_alusel == SEL_MULDIV) && (ex_aluop < 5'd4);
        md_is_div = ex_aluop[1];
        md_signed = !ex_aluop[0];
        div_zero  = md_is_div && (ex_srcr == '0);
        issue     = (state == IDLE) && md_start && !flush && !rst;
        a_neg     = md_signed && ex_srcl[DW-1];
        b_neg     = md_signed && ex_srcr[DW-1];
        a_abs     = a_neg ? -ex_srcl : ex_srcl;
        b_abs     = b_neg ? -ex_srcr : ex_srcr;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (issue) state_nxt = div_zero ? DONE : BUSY;
            BUSY: if (cnt == CW'(DW-1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    assign stall_req = !rst && (issue || (state == BUSY));

    // ---------------- iteration datapath ----------------
    // acc holds {partial, multiplier} for mul and {remainder, dividend/quotient} for div.
    logic [DW:0]     mul_sum, div_r;
    logic            div_ge;
    logic [DW-1:0]   div_rem;
    logic [2*DW-1:0] step_nxt, prod_fix;
    logic [DW-1:0]   fin_hi, fin_lo;

    always_comb begin
        mul_sum  = {1'b0, acc[2*DW-1:DW]} + {1'b0, (acc[0] ? mcand : {DW{1'b0}})};
        div_r    = {acc[2*DW-1:DW], acc[DW-1]};
        div_ge   = div_r >= {1'b0, mcand};
        div_rem  = div_ge ? DW'(div_r - {1'b0, mcand}) : div_r[DW-1:0];
        step_nxt = op_div ? {div_rem, acc[DW-2:0], div_ge}
                          : {mul_sum, acc[DW-1:1]};
        prod_fix = neg_q ? -acc : acc;
        if (op_div) begin
            fin_lo = neg_q ? -acc[DW-1:0] : acc[DW-1:0];
            fin_hi = neg_r ? -acc[2*DW-1:DW] : acc[2*DW-1:DW];
        end else begin
            fin_lo = prod_fix[DW-1:0];
            fin_hi = prod_fix[2*DW-1:DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            mcand  <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        cnt    <= '0;
                        op_div <= md_is_div;
                        neg_q  <= !div_zero && (a_neg ^ b_neg);
                        neg_r  <= !div_zero && md_is_div && a_neg;
                        mcand  <= md_is_div ? b_abs : a_abs;
                        // Divide by zero skips BUSY: preload the architected result.
                        if (div_zero)       acc <= {ex_srcl, {DW{1'b1}}};
                        else if (md_is_div) acc <= {{DW{1'b0}}, a_abs};
                        else                acc <= {{DW{1'b0}}, b_abs};
                    end
                    if (ex_alusel == SEL_MULDIV && ex_aluop == MD_MTHI) hi <= ex_srcl;
                    if (ex_alusel == SEL_MULDIV && ex_aluop == MD_MTLO) lo <= ex_srcl;
                end
                BUSY: begin
                    acc <= step_nxt;
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    if (!flush) begin
                        hi <= fin_hi;
                        lo <= fin_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- single-cycle ALU ----------------
    logic [DW-1:0] alu_res, sum, diff;
    logic [SW-1:0] shamt;
    logic          alu_valid, alu_ovf;

    always_comb begin
        alu_res   = '0;
        alu_valid = 1'b0;
        alu_ovf   = 1'b0;
        sum       = ex_srcl + ex_srcr;
        diff      = ex_srcl - ex_srcr;
        shamt     = ex_srcr[SW-1:0];
        case (ex_alusel)
            SEL_LOGIC: begin
                alu_valid = 1'b1;
                case (ex_aluop)
                    5'd0: alu_res = ex_srcl & ex_srcr;
                    5'd1: alu_res = ex_srcl | ex_srcr;
                    5'd2: alu_res = ex_srcl ^ ex_srcr;
                    5'd3: alu_res = ~(ex_srcl | ex_srcr);
                    5'd4: alu_res = DW'(ex_srcr[15:0]) << 16;
                    default: alu_valid = 1'b0;
                endcase
            end
            SEL_SHIFT: begin
                alu_valid = 1'b1;
                case (ex_aluop)
                    5'd0: alu_res = ex_srcl << shamt;
                    5'd1: alu_res = ex_srcl >> shamt;
                    5'd2: alu_res = $signed(ex_srcl) >>> shamt;
                    default: alu_valid = 1'b0;
                endcase
            end
            SEL_ARITH: begin
                alu_valid = 1'b1;
                case (ex_aluop)
                    5'd0: begin
                        alu_res = sum;
                        alu_ovf = (ex_srcl[DW-1] == ex_srcr[DW-1]) && (sum[DW-1] != ex_srcl[DW-1]);
                    end
                    5'd1: begin
                        alu_res = diff;
                        alu_ovf = (ex_srcl[DW-1] != ex_srcr[DW-1]) && (diff[DW-1] != ex_srcl[DW-1]);
                    end
                    5'd2: alu_res = {{(DW-1){1'b0}}, $signed(ex_srcl) < $signed(ex_srcr)};
                    5'd3: alu_res = {{(DW-1){1'b0}}, ex_srcl < ex_srcr};
                    5'd4: alu_res = sum;
                    5'd5: alu_res = diff;
                    default: alu_valid = 1'b0;
                endcase
            end
            SEL_MOVE: begin
                alu_valid = 1'b1;
                case (ex_aluop)
                    5'd0: alu_res = hi;
                    5'd1: alu_res = lo;
                    default: alu_valid = 1'b0;
                endcase
            end
            default: ;
        endcase
        if (!alu_valid) alu_res = '0;
    end

    // ---------------- EX/MEM bundle ----------------
    always_comb begin
        mem_result      = rst ? '0 : alu_res;
        mem_addr        = rst ? '0 : ex_srcl + {{(DW-16){ex_offset[15]}}, ex_offset};
        mem_storedata   = rst ? '0 : ex_srcr;
        mem_memop       = (rst || stall_req) ? 3'd0 : ex_memop;
        mem_dest        = rst ? 5'd0 : ex_dest;
        ovf_exc         = !rst && alu_ovf;
        mem_writeEnable = !rst && !stall_req && ex_writeEnable && alu_valid && !alu_ovf;
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: a behavioural model (plain arithmetic + countdown for
// the mul/div latency) is compared every cycle, plus literal expectations.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [2:0]  ex_alusel = 3'd3;
    logic [4:0]  ex_aluop = 5'd0;
    logic [31:0] ex_srcl = 32'h5, ex_srcr = 32'h6;
    logic [15:0] ex_offset = 16'h1;
    logic [2:0]  ex_memop = 3'd3;
    logic [4:0]  ex_dest = 5'd7;
    logic        ex_writeEnable = 1'b1;
    logic [31:0] mem_result, mem_addr, mem_storedata;
    logic [2:0]  mem_memop;
    logic [4:0]  mem_dest;
    logic        mem_writeEnable, ovf_exc, stall_req;

    ex_stage #(.DW(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_alusel(ex_alusel), .ex_aluop(ex_aluop), .ex_srcl(ex_srcl), .ex_srcr(ex_srcr),
        .ex_offset(ex_offset), .ex_memop(ex_memop), .ex_dest(ex_dest),
        .ex_writeEnable(ex_writeEnable),
        .mem_result(mem_result), .mem_addr(mem_addr), .mem_storedata(mem_storedata),
        .mem_memop(mem_memop), .mem_dest(mem_dest), .mem_writeEnable(mem_writeEnable),
        .ovf_exc(ovf_exc), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- model ----------------
    logic [31:0] m_hi = 0, m_lo = 0;
    logic [63:0] m_pend = 0;
    int          m_left = 0;   // cycles until the mul/div retires; 1 = retire cycle

    function automatic logic md_op(input logic [2:0] s, input logic [4:0] o);
        return s == 3'd4 && o < 5'd4;
    endfunction

    function automatic logic [63:0] md_calc(input logic [4:0] o, input logic [31:0] l, input logic [31:0] r);
        longint a, b, q, m;
        logic [63:0] p;
        case (o)
            5'd0: begin p = 64'(longint'($signed(l)) * longint'($signed(r))); return p; end
            5'd1: begin p = {32'h0, l} * {32'h0, r}; return p; end
            5'd2: begin
                if (r == 0) return {l, 32'hFFFF_FFFF};
                a = longint'($signed(l)); b = longint'($signed(r));
                q = a / b; m = a % b;
                return {m[31:0], q[31:0]};
            end
            default: begin
                if (r == 0) return {l, 32'hFFFF_FFFF};
                return {l % r, l / r};
            end
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_hi <= 0; m_lo <= 0; m_left <= 0;
        end else if (m_left == 0) begin
            if (ex_alusel == 3'd4 && ex_aluop == 5'd4) m_hi <= ex_srcl;
            if (ex_alusel == 3'd4 && ex_aluop == 5'd5) m_lo <= ex_srcl;
            if (md_op(ex_alusel, ex_aluop) && !flush) begin
                m_pend <= md_calc(ex_aluop, ex_srcl, ex_srcr);
                m_left <= (ex_aluop[1] && ex_srcr == 0) ? 1 : 33;
            end
        end else if (flush) begin
            m_left <= 0;
        end else begin
            if (m_left == 1) begin m_hi <= m_pend[63:32]; m_lo <= m_pend[31:0]; end
            m_left <= m_left - 1;
        end
    end

    logic [31:0] e_res, e_addr;
    logic        e_valid, e_ovf, e_stall, e_we;
    longint      e_s;

    always @(negedge clk) begin
        e_res = 0; e_valid = 1'b1; e_ovf = 1'b0; e_s = 0;
        case (ex_alusel)
            3'd1: case (ex_aluop)
                5'd0: e_res = ex_srcl & ex_srcr;
                5'd1: e_res = ex_srcl | ex_srcr;
                5'd2: e_res = ex_srcl ^ ex_srcr;
                5'd3: e_res = ~(ex_srcl | ex_srcr);
                5'd4: e_res = {ex_srcr[15:0], 16'h0};
                default: e_valid = 1'b0;
            endcase
            3'd2: case (ex_aluop)
                5'd0: e_res = ex_srcl << ex_srcr[4:0];
                5'd1: e_res = ex_srcl >> ex_srcr[4:0];
                5'd2: e_res = $signed(ex_srcl) >>> ex_srcr[4:0];
                default: e_valid = 1'b0;
            endcase
            3'd3: case (ex_aluop)
                5'd0, 5'd1: begin
                    e_s = (ex_aluop == 5'd0) ? longint'($signed(ex_srcl)) + longint'($signed(ex_srcr))
                                             : longint'($signed(ex_srcl)) - longint'($signed(ex_srcr));
                    e_res = e_s[31:0];
                    e_ovf = (e_s > 64'sd2147483647) || (e_s < -64'sd2147483648);
                end
                5'd2: e_res = ($signed(ex_srcl) < $signed(ex_srcr)) ? 1 : 0;
                5'd3: e_res = (ex_srcl < ex_srcr) ? 1 : 0;
                5'd4: e_res = ex_srcl + ex_srcr;
                5'd5: e_res = ex_srcl - ex_srcr;
                default: e_valid = 1'b0;
            endcase
            3'd5: case (ex_aluop)
                5'd0: e_res = m_hi;
                5'd1: e_res = m_lo;
                default: e_valid = 1'b0;
            endcase
            default: e_valid = 1'b0;
        endcase
        if (!e_valid) e_res = 0;
        e_addr  = ex_srcl + {{16{ex_offset[15]}}, ex_offset};
        e_stall = !rst && (m_left > 1 || (m_left == 0 && md_op(ex_alusel, ex_aluop) && !flush));
        e_we    = !rst && !e_stall && ex_writeEnable && e_valid && !e_ovf;
        check("m_result", mem_result, rst ? 32'h0 : e_res);
        check("m_addr", mem_addr, rst ? 32'h0 : e_addr);
        check("m_store", mem_storedata, rst ? 32'h0 : ex_srcr);
        check("m_memop", 32'(mem_memop), (rst || e_stall) ? 32'h0 : 32'(ex_memop));
        check("m_dest", 32'(mem_dest), rst ? 32'h0 : 32'(ex_dest));
        check("m_we", 32'(mem_writeEnable), 32'(e_we));
        check("m_ovf", 32'(ovf_exc), 32'(!rst && e_ovf));
        check("m_stall", 32'(stall_req), 32'(e_stall));
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic [2:0] s, input logic [4:0] o, input logic [31:0] l,
                         input logic [31:0] r, input logic [15:0] off = 16'h0);
        @(posedge clk); #1;
        ex_alusel = s; ex_aluop = o; ex_srcl = l; ex_srcr = r; ex_offset = off;
        ex_memop = 3'd2; ex_dest = 5'd9; ex_writeEnable = 1'b1;
    endtask

    task automatic wait_stall(output int n);
        n = 0;
        @(negedge clk);
        while (stall_req && n < 200) begin n++; @(negedge clk); end
    endtask

    int n;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_result", mem_result, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        drive(3'd3, 5'd0, 32'h7FFF_FFFF, 32'h1); @(negedge clk);
        check("add_res", mem_result, 32'h8000_0000);
        check("add_ovf", 32'(ovf_exc), 32'h1);
        check("add_we", 32'(mem_writeEnable), 32'h0);
        drive(3'd3, 5'd4, 32'h7FFF_FFFF, 32'h1); @(negedge clk);
        check("addu_we", 32'(mem_writeEnable), 32'h1);
        check("addu_ovf", 32'(ovf_exc), 32'h0);
        drive(3'd3, 5'd1, 32'h8000_0000, 32'h1); @(negedge clk);
        check("sub_ovf", 32'(ovf_exc), 32'h1);
        drive(3'd2, 5'd2, 32'h8000_0000, 32'd31); @(negedge clk);
        check("sra", mem_result, 32'hFFFF_FFFF);
        drive(3'd1, 5'd4, 32'h0, 32'h0000_ABCD); @(negedge clk);
        check("lui", mem_result, 32'hABCD_0000);
        drive(3'd1, 5'd0, 32'h100, 32'h0, 16'hFFFC); @(negedge clk);
        check("addr", mem_addr, 32'h0000_00FC);
        drive(3'd7, 5'd0, 32'h1, 32'h2); @(negedge clk);
        check("undef_we", 32'(mem_writeEnable), 32'h0);

        drive(3'd4, 5'd0, 32'hFFFF_FFFD, 32'd7); wait_stall(n);
        check("mult_stall", n, 33);
        drive(3'd5, 5'd1, 32'h0, 32'h0); @(negedge clk);
        check("mult_lo", mem_result, 32'hFFFF_FFEB);
        drive(3'd5, 5'd0, 32'h0, 32'h0); @(negedge clk);
        check("mult_hi", mem_result, 32'hFFFF_FFFF);

        drive(3'd4, 5'd2, 32'hFFFF_FFF9, 32'd2); wait_stall(n);
        drive(3'd5, 5'd1, 32'h0, 32'h0); @(negedge clk);
        check("div_lo", mem_result, 32'hFFFF_FFFD);
        drive(3'd5, 5'd0, 32'h0, 32'h0); @(negedge clk);
        check("div_hi", mem_result, 32'hFFFF_FFFF);

        drive(3'd4, 5'd3, 32'd7, 32'd2); wait_stall(n);
        drive(3'd5, 5'd1, 32'h0, 32'h0); @(negedge clk);
        check("divu_lo", mem_result, 32'd3);
        drive(3'd5, 5'd0, 32'h0, 32'h0); @(negedge clk);
        check("divu_hi", mem_result, 32'd1);

        drive(3'd4, 5'd3, 32'h1234, 32'h0); wait_stall(n);
        check("dz_stall", n, 1);
        drive(3'd5, 5'd0, 32'h0, 32'h0); @(negedge clk);
        check("dz_hi", mem_result, 32'h1234);
        drive(3'd5, 5'd1, 32'h0, 32'h0); @(negedge clk);
        check("dz_lo", mem_result, 32'hFFFF_FFFF);

        // Flush in BUSY cycle 10: the bubble that follows must not stall.
        drive(3'd4, 5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (11) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0; ex_alusel = 3'd0; ex_aluop = 5'd0;
        @(negedge clk);
        check("flush_stall", 32'(stall_req), 32'h0);
        drive(3'd5, 5'd0, 32'h0, 32'h0); @(negedge clk);
        check("flush_hi", mem_result, 32'h1234);
        drive(3'd5, 5'd1, 32'h0, 32'h0); @(negedge clk);
        check("flush_lo", mem_result, 32'hFFFF_FFFF);

        drive(3'd4, 5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; ex_alusel = 3'd0; ex_aluop = 5'd0;
        drive(3'd5, 5'd0, 32'h0, 32'h0); @(negedge clk);
        check("rst_hi", mem_result, 32'h0);
        drive(3'd5, 5'd1, 32'h0, 32'h0); @(negedge clk);
        check("rst_lo", mem_result, 32'h0);

        drive(3'd4, 5'd4, 32'hCAFE_F00D, 32'h0); @(negedge clk);
        check("mthi_we", 32'(mem_writeEnable), 32'h0);
        drive(3'd4, 5'd5, 32'h0BAD_BEEF, 32'h0);
        drive(3'd5, 5'd0, 32'h0, 32'h0); @(negedge clk);
        check("mthi", mem_result, 32'hCAFE_F00D);
        drive(3'd5, 5'd1, 32'h0, 32'h0); @(negedge clk);
        check("mtlo", mem_result, 32'h0BAD_BEEF);

        drive(3'd0, 5'd0, 32'h0, 32'h0);
        @(posedge clk); #2;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage toy CPU.
- Consumes the registered ID/EX bundle (alusel, aluop, srcl, srcr, offset, memop, dest, writeEnable) and produces the result bundle for the EX/MEM register.
- Contains a single-cycle ALU (logic, shift, arithmetic, address) and an iterative 32-cycle multiply/divide unit with architectural HI/LO registers.
- Raises a stall request to freeze IF/ID/ID_EX while a mul/div is in flight.

Parameters:
- DW, 32, datapath width; the mul/div iteration count equals DW.

Ports:
- clk  in  1  clock; everything samples on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  cancel the in-flight mul/div; no HI/LO update.
- ex_alusel  in  3  unit select: 0 NOP, 1 LOGIC, 2 SHIFT, 3 ARITH, 4 MULDIV, 5 MOVE.
- ex_aluop  in  5  operation within the selected unit.
- ex_srcl  in  32  left operand (rs).
- ex_srcr  in  32  right operand (rt or extended immediate).
- ex_offset  in  16  memory offset, sign-extended internally.
- ex_memop  in  3  memory op, passed through.
- ex_dest  in  5  destination register, passed through.
- ex_writeEnable  in  1  register write request.
- mem_result  out  32  ALU result.
- mem_addr  out  32  srcl + sext(offset), always computed.
- mem_storedata  out  32  equals srcr.
- mem_memop  out  3  pass-through.
- mem_dest  out  5  pass-through.
- mem_writeEnable  out  1  qualified write enable.
- ovf_exc  out  1  signed overflow on ADD/SUB.
- stall_req  out  1  freeze upstream stages; EX/MEM takes a bubble.

Behaviour:
- Reset:
  - While rst is high, all outputs are forced to 0.
  - HI, LO and the FSM registers clear on the clock edge; FSM returns to IDLE.
  - rst mid-operation aborts the mul/div with no HI/LO write.
- LOGIC aluop: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 LUI (srcr[15:0]<<16).
- SHIFT aluop: 0 SLL, 1 SRL, 2 SRA. Shift amount is srcr[4:0]; the value is srcl.
- ARITH aluop: 0 ADD, 1 SUB, 2 SLT (signed), 3 SLTU, 4 ADDU, 5 SUBU. All results are 32-bit wrap.
- Overflow: on signed overflow of ADD/SUB, ovf_exc=1 and mem_writeEnable=0. The U variants never overflow.
- MOVE aluop: 0 MFHI, 1 MFLO. Reads the current HI/LO register value.
- MULDIV aluop: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO.
  - mem_writeEnable is always 0 for MULDIV.
  - MTHI/MTLO write srcl to HI/LO at the edge, no stall.
- NOP or an undefined op: mem_result=0, mem_writeEnable=0.
- Default writeback: mem_writeEnable = ex_writeEnable unless suppressed by one of the rules above.
- FSM states: IDLE, BUSY, DONE.
  - IDLE→BUSY on MULT/MULTU/DIV/DIVU while flush=0. Latch |operands| and result signs (signed ops only). Counter = 0.
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle. Counter increments; at 31 → DONE.
  - DONE: apply sign correction, then write HI/LO.
    - mul: {HI,LO} = 64-bit product.
    - div: LO = quotient (truncates toward zero), HI = remainder (carries the sign of the dividend).
  - DONE → IDLE unconditionally.
- Divide by zero: IDLE→DONE directly. HI=srcl, LO=32'hFFFF_FFFF. stall_req is high for the issue cycle only.
- stall_req:
  - Combinationally high in the issue cycle (IDLE with a mul/div op decoded) and throughout BUSY.
  - Low in DONE and IDLE.
  - Normal mul/div: 33 stall cycles, then HI/LO valid at the end of the DONE cycle.
  - While stalled, mem_writeEnable=0 and mem_memop=0 (bubble to MEM).
- Inputs are held stable by upstream during the stall. The unit must not re-trigger in DONE because the state is not IDLE. The instruction retires in the DONE cycle.
- flush: any state → IDLE next edge, no HI/LO write. Flush has priority over the DONE write.
- Ordering: MFHI/MFLO following a mul/div sees the new value, guaranteed by the stall. MTHI in the same cycle as an abort has no conflict because an MTHI can only be issued in IDLE.

Test Plan:
- ADD 0x7FFFFFFF+1, writeEnable=1 → result 0x80000000, ovf_exc=1, mem_writeEnable=0. Same operands with ADDU → writeEnable=1, no exc.
- MULT srcl=-3 (0xFFFFFFFD), srcr=7 → stall_req high 33 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFEB. Following MFLO returns 0xFFFFFFEB.
- DIV srcl=-7, srcr=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 7/2 → LO=3, HI=1.
- DIVU srcr=0, srcl=0x1234 → stall_req for 1 cycle only, HI=0x1234, LO=0xFFFFFFFF.
- MULTU 0xFFFFFFFF×0xFFFFFFFF with flush at BUSY cycle 10 → FSM IDLE next cycle, stall_req low, HI/LO unchanged. Repeat with rst instead → HI=LO=0.
- SRA srcl=0x80000000, srcr=31 → 0xFFFFFFFF. LUI srcr=0xABCD → 0xABCD0000. mem_addr with srcl=0x100, offset=0xFFFC → 0xFC.
